fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_if.sv | 26 ++
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_unit.sv | 90 +++++++++
 tb/tb_fetch_unit.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch unit.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam int unsigned FETCH_DEPTH      = 2;
    localparam int unsigned CNT_W            = $clog2(FETCH_DEPTH + 1);
    localparam int unsigned SUM_W            = CNT_W + 1;

endpackage

// File: rtl/fetch_if.sv
// Instruction memory request/response bus between fetch and memory.
interface fetch_if #(
    parameter int unsigned W = 32
);
    logic         imem_req_valid;
    logic         imem_req_ready;
    logic [W-1:0] imem_req_addr;
    logic         imem_rsp_valid;
    logic [W-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_fifo.sv
// Two-entry {instr, pc} buffer between memory responses and decode.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [W-1:0]     i_instr,
    input  logic [W-1:0]     i_pc,
    input  logic             i_pop,
    input  logic             i_clear,
    output logic [W-1:0]     o_instr,
    output logic [W-1:0]     o_pc,
    output logic [CNT_W-1:0] o_count
);
    localparam int unsigned PTR_W = $clog2(FETCH_DEPTH);

    logic [W-1:0]     r_instr [FETCH_DEPTH];
    logic [W-1:0]     r_pc    [FETCH_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    // Pointer and occupancy tracking; clear wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    // Entry storage; contents are qualified by r_count so no reset needed.
    always_ff @(posedge clk) begin
        if (i_push && !i_clear) begin
            r_instr[r_wr_ptr] <= i_instr;
            r_pc[r_wr_ptr]    <= i_pc;
        end
    end

    assign o_instr = r_instr[r_rd_ptr];
    assign o_pc    = r_pc[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, credit-limited requests, redirect squash.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned                word_width = 32,
    parameter logic [word_width-1:0]      RESET_PC   = word_width'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  StallF,
    input  logic                  PCSrcE,
    input  logic [word_width-1:0] PCTargetE,
    fetch_if.master               imem,
    output logic [word_width-1:0] InstrF,
    output logic [word_width-1:0] PCF,
    output logic [word_width-1:0] PCPlus4F,
    output logic                  InstrValidF
);
    localparam logic [word_width-1:0] PC_STEP = word_width'(4);

    logic [word_width-1:0] r_fetch_pc;
    logic [word_width-1:0] r_resp_pc;
    logic [CNT_W-1:0]      r_pending;
    logic [CNT_W-1:0]      r_drop;

    logic [CNT_W-1:0]      w_count;
    logic [word_width-1:0] w_head_instr;
    logic [word_width-1:0] w_head_pc;
    logic [SUM_W-1:0]      w_credit_used;
    logic                  w_req_valid;
    logic                  w_fire;
    logic                  w_keep;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_pending_nxt;

    // Request only while slots remain for every outstanding or buffered word.
    assign w_credit_used = SUM_W'(r_pending) + SUM_W'(w_count);
    assign w_req_valid   = rst_n & ~PCSrcE & (w_credit_used < SUM_W'(FETCH_DEPTH));
    assign w_fire        = w_req_valid & imem.imem_req_ready;
    assign w_keep        = imem.imem_rsp_valid & (r_drop == '0) & ~PCSrcE;
    assign w_pop         = InstrValidF & ~StallF & ~PCSrcE;
    assign w_pending_nxt = r_pending + CNT_W'(w_fire) - CNT_W'(imem.imem_rsp_valid);

    assign imem.imem_req_valid = w_req_valid;
    assign imem.imem_req_addr  = r_fetch_pc;

    // PC and in-flight bookkeeping; a redirect squashes everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_pending  <= '0;
            r_drop     <= '0;
        end else if (PCSrcE) begin
            r_fetch_pc <= PCTargetE;
            r_resp_pc  <= PCTargetE;
            r_pending  <= w_pending_nxt;
            r_drop     <= w_pending_nxt;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_fire) r_fetch_pc <= r_fetch_pc + PC_STEP;
            if (imem.imem_rsp_valid) begin
                if (r_drop != '0) r_drop    <= r_drop - CNT_W'(1);
                else              r_resp_pc <= r_resp_pc + PC_STEP;
            end
        end
    end

    fetch_fifo #(
        .W (word_width)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_keep),
        .i_instr (imem.imem_rsp_data),
        .i_pc    (r_resp_pc),
        .i_pop   (w_pop),
        .i_clear (PCSrcE),
        .o_instr (w_head_instr),
        .o_pc    (w_head_pc),
        .o_count (w_count)
    );

    // Decode-facing view of the buffer head; empty shows a NOP at resp_pc.
    assign InstrValidF = (w_count != '0);
    assign InstrF      = InstrValidF ? w_head_instr : word_width'(NOP_INSTR);
    assign PCF         = InstrValidF ? w_head_pc : r_resp_pc;
    assign PCPlus4F    = PCF + PC_STEP;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit with an in-order 1-cycle memory.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         StallF;
    logic         PCSrcE;
    logic [W-1:0] PCTargetE;
    logic [W-1:0] InstrF;
    logic [W-1:0] PCF;
    logic [W-1:0] PCPlus4F;
    logic         InstrValidF;

    fetch_if #(.W(W)) imem ();

    fetch_unit #(
        .word_width (W),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .StallF      (StallF),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .imem        (imem.master),
        .InstrF      (InstrF),
        .PCF         (PCF),
        .PCPlus4F    (PCPlus4F),
        .InstrValidF (InstrValidF)
    );

    always #5 clk = ~clk;

    logic [31:0] sb[$];
    logic [31:0] inflight[$];
    int          n_vec;
    int          n_err;
    int          fire_cnt;
    logic [31:0] exp_fetch;
    logic        last_fire;
    logic [31:0] last_addr;
    logic        prev_wait;
    logic [31:0] prev_addr;
    logic        rsp_hold;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #3;
    endtask

    // Output/request checks at mid-cycle, then clock edge and memory response.
    task automatic finish_cycle();
        logic cons;
        logic fire;
        cons = InstrValidF & ~StallF & ~PCSrcE;
        if (!PCSrcE && InstrValidF) begin
            if (sb.size() == 0) begin
                chk("no_extra_instr", 32'(cons), 32'h0);
            end else begin
                chk("pcf", PCF, sb[0]);
                chk("instr", InstrF, mem_word(sb[0]));
                chk("pcplus4", PCPlus4F, sb[0] + 32'd4);
                if (cons) void'(sb.pop_front());
            end
        end
        fire = imem.imem_req_valid & imem.imem_req_ready;
        if (fire) begin
            chk("req_addr", imem.imem_req_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            fire_cnt++;
        end
        if (prev_wait && !PCSrcE) begin
            chk("hold_valid", 32'(imem.imem_req_valid), 32'h1);
            chk("hold_addr", imem.imem_req_addr, prev_addr);
        end
        prev_wait = imem.imem_req_valid & ~imem.imem_req_ready;
        prev_addr = imem.imem_req_addr;
        last_fire = fire;
        last_addr = imem.imem_req_addr;
        @(posedge clk);
        #1;
        if (last_fire) inflight.push_back(last_addr);
        if (!rsp_hold && inflight.size() != 0) begin
            imem.imem_rsp_valid = 1'b1;
            imem.imem_rsp_data  = mem_word(inflight.pop_front());
        end else begin
            imem.imem_rsp_valid = 1'b0;
            imem.imem_rsp_data  = '0;
        end
    endtask

    task automatic step();
        settle();
        finish_cycle();
    endtask

    task automatic run_drain(input int budget, input string tag);
        for (int k = 0; k < budget && sb.size() != 0; k++) step();
        StallF = 1'b1;
        chk({"drain_", tag}, 32'(sb.size()), 32'h0);
    endtask

    task automatic stall_cycles(input int n);
        StallF = 1'b1;
        repeat (n) step();
    endtask

    task automatic redirect(input logic [31:0] tgt);
        PCSrcE    = 1'b1;
        PCTargetE = tgt;
        settle();
        chk("redir_no_req", 32'(imem.imem_req_valid), 32'h0);
        finish_cycle();
        PCSrcE = 1'b0;
        sb.delete();
        exp_fetch = tgt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0; fire_cnt = 0;
        rst_n = 1'b0; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        imem.imem_req_ready = 1'b1;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = '0;
        rsp_hold = 1'b0; last_fire = 1'b0; last_addr = '0;
        prev_wait = 1'b0; prev_addr = '0; exp_fetch = 32'h0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        settle();
        chk("rst_req_valid", 32'(imem.imem_req_valid), 32'h0);
        chk("rst_req_addr", imem.imem_req_addr, 32'h0);
        chk("rst_valid", 32'(InstrValidF), 32'h0);
        chk("rst_instr", InstrF, NOP_INSTR);
        chk("rst_pcf", PCF, 32'h0);
        finish_cycle();

        // Streaming after reset: first request immediately, valid after 2 cycles
        rst_n = 1'b1;
        sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
        settle();
        chk("first_req", 32'(imem.imem_req_valid), 32'h1);
        chk("lat_c0", 32'(InstrValidF), 32'h0);
        finish_cycle();
        settle();
        chk("lat_c1", 32'(InstrValidF), 32'h0);
        finish_cycle();
        settle();
        chk("lat_c2", 32'(InstrValidF), 32'h1);
        finish_cycle();
        run_drain(20, "stream");

        // Stall for four cycles: PCF frozen, bounded requests, no loss on release
        sb.push_back(32'hC); sb.push_back(32'h10); sb.push_back(32'h14); sb.push_back(32'h18);
        fire_cnt = 0;
        StallF = 1'b1;
        repeat (3) step();
        settle();
        chk("stall_valid", 32'(InstrValidF), 32'h1);
        chk("stall_pcf", PCF, 32'hC);
        finish_cycle();
        chk("stall_fires_le2", 32'(fire_cnt <= 2), 32'h1);
        StallF = 1'b0;
        run_drain(30, "stall");

        // Redirect with two requests outstanding
        sb.push_back(32'h1C); sb.push_back(32'h20); sb.push_back(32'h24); sb.push_back(32'h28);
        rsp_hold = 1'b1;
        StallF   = 1'b0;
        repeat (6) step();
        chk("two_pending", 32'(inflight.size()), 32'h2);
        redirect(32'h100);
        sb.push_back(32'h100); sb.push_back(32'h104); sb.push_back(32'h108);
        rsp_hold = 1'b0;
        settle();
        chk("redir_empty", 32'(InstrValidF), 32'h0);
        finish_cycle();
        run_drain(30, "redir");

        // Redirect coincident with a response and a stall
        stall_cycles(4);
        rsp_hold = 1'b1;
        redirect(32'h200);
        repeat (3) step();
        chk("coinc_two_pending", 32'(inflight.size()), 32'h2);
        rsp_hold = 1'b0;
        step();
        PCSrcE = 1'b1; PCTargetE = 32'h100; StallF = 1'b1; rsp_hold = 1'b1;
        step();
        PCSrcE = 1'b0; StallF = 1'b0; rsp_hold = 1'b0;
        sb.delete();
        exp_fetch = 32'h100;
        sb.push_back(32'h100); sb.push_back(32'h104); sb.push_back(32'h108);
        settle();
        chk("coinc_empty", 32'(InstrValidF), 32'h0);
        chk("coinc_req", 32'(imem.imem_req_valid), 32'h1);
        chk("coinc_addr", imem.imem_req_addr, 32'h100);
        finish_cycle();
        run_drain(30, "coinc");

        // Memory not ready for three cycles
        stall_cycles(4);
        imem.imem_req_ready = 1'b0;
        redirect(32'h300);
        StallF = 1'b0;
        sb.push_back(32'h300); sb.push_back(32'h304);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("nr_valid", 32'(imem.imem_req_valid), 32'h1);
            chk("nr_addr", imem.imem_req_addr, 32'h300);
            finish_cycle();
        end
        imem.imem_req_ready = 1'b1;
        settle();
        chk("nr_fire_valid", 32'(imem.imem_req_valid), 32'h1);
        chk("nr_fire_addr", imem.imem_req_addr, 32'h300);
        finish_cycle();
        run_drain(30, "ready");

        // Address wrap at the top of the address space
        stall_cycles(4);
        redirect(32'hFFFF_FFFC);
        StallF = 1'b0;
        sb.push_back(32'hFFFF_FFFC); sb.push_back(32'h0); sb.push_back(32'h4);
        run_drain(30, "wrap");
        stall_cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
